// File: rtl/arbitro_display_pkg.sv
// Shared types and defaults for the display arbiter slice.
package tipos_pacotes;

    typedef enum logic [1:0] {
        LIVRE = 2'd0,
        OPER  = 2'd1,
        SETUP = 2'd2,
        TROCA = 2'd3
    } estado_arb_t;

    localparam int MIN_HOLD_DEF = 16;
    localparam int TIMEOUT_DEF  = 1000;
    localparam int GAP_DEF      = 2;

    // Six packed BCD digits feeding the HEX display.
    typedef logic [5:0][3:0] bcdPac_t;

    // Counter width able to hold 0..max; a zero max still needs one bit.
    function automatic int cnt_w(input int max);
        return (max > 0) ? $clog2(max + 1) : 1;
    endfunction

endpackage

// File: rtl/arbitro_display_contador_sat.sv
// Saturating up-counter with synchronous clear; never wraps past MAX.
module contador_sat
    import tipos_pacotes::*;
#(
    parameter int MAX = 1,
    localparam int W  = cnt_w(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         at_max_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i)
            cnt_q <= '0;
        else if (en_i && !at_max_o)
            cnt_q <= cnt_q + 1'b1;
    end

    assign cnt_o    = cnt_q;
    assign at_max_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/arbitro_display.sv
// Two-way arbiter for the shared HEX display: setup priority, operational
// minimum hold, setup inactivity timeout and a blank gap on every handover.
module arbitro_display
    import tipos_pacotes::*;
#(
    parameter int MIN_HOLD = MIN_HOLD_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF,
    parameter int GAP      = GAP_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic req_o,
    input  logic req_s,
    input  logic atividade_s,
    output logic gnt_o,
    output logic gnt_s,
    output logic ocupado,
    output logic timeout_s
);

    localparam int WH = cnt_w(MIN_HOLD);
    localparam int WI = cnt_w(TIMEOUT);
    localparam int WG = cnt_w(GAP);

    localparam logic [WI-1:0] IDLE_LAST = WI'(TIMEOUT - 1);
    localparam logic [WG-1:0] GAP_LAST  = WG'(GAP - 1);

    estado_arb_t   estado_q;
    logic          lock_s_q;
    logic          timeout_q;
    logic [WH-1:0] hold_cnt;
    logic [WI-1:0] idle_cnt;
    logic [WG-1:0] gap_cnt;
    logic          hold_max, idle_max, gap_max;
    logic          req_s_ef;
    logic          expira;

    // Counters sit at zero outside their state, so each starts at 0 on entry.
    contador_sat #(.MAX(MIN_HOLD)) u_hold (
        .clk(clk), .rst(rst), .clr_i(estado_q != OPER), .en_i(1'b1),
        .cnt_o(hold_cnt), .at_max_o(hold_max)
    );

    contador_sat #(.MAX(TIMEOUT)) u_idle (
        .clk(clk), .rst(rst), .clr_i((estado_q != SETUP) || atividade_s), .en_i(1'b1),
        .cnt_o(idle_cnt), .at_max_o(idle_max)
    );

    contador_sat #(.MAX(GAP)) u_gap (
        .clk(clk), .rst(rst), .clr_i(estado_q != TROCA), .en_i(1'b1),
        .cnt_o(gap_cnt), .at_max_o(gap_max)
    );

    logic unused_max;
    assign unused_max = idle_max ^ gap_max;

    assign req_s_ef = req_s && !lock_s_q;
    // Activity in the same cycle overrides an expiring idle count.
    assign expira   = (TIMEOUT != 0) && (idle_cnt == IDLE_LAST) && !atividade_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= LIVRE;
            lock_s_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (!req_s)
                lock_s_q <= 1'b0;
            case (estado_q)
                LIVRE: begin
                    if (req_s_ef)   estado_q <= SETUP;
                    else if (req_o) estado_q <= OPER;
                end
                OPER: begin
                    if (!req_o || (req_s_ef && hold_max))
                        estado_q <= TROCA;
                end
                SETUP: begin
                    if (!req_s) begin
                        estado_q <= TROCA;
                    end else if (expira) begin
                        estado_q  <= TROCA;
                        lock_s_q  <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                TROCA: begin
                    if (gap_cnt == GAP_LAST)
                        estado_q <= LIVRE;
                end
                default: estado_q <= LIVRE;
            endcase
        end
    end

    assign gnt_o     = (estado_q == OPER);
    assign gnt_s     = (estado_q == SETUP);
    assign ocupado   = gnt_o | gnt_s;
    assign timeout_s = timeout_q;

endmodule

// File: tb/tb_arbitro_display.sv
// Directed bench for arbitro_display with MIN_HOLD=4, TIMEOUT=8, GAP=2.
module tb_arbitro_display;
    import tipos_pacotes::*;

    logic clk = 1'b0;
    logic rst, req_o, req_s, atividade_s;
    logic gnt_o, gnt_s, ocupado, timeout_s;
    int   n_run  = 0;
    int   n_fail = 0;

    arbitro_display #(.MIN_HOLD(4), .TIMEOUT(8), .GAP(2)) dut (
        .clk(clk), .rst(rst), .req_o(req_o), .req_s(req_s),
        .atividade_s(atividade_s), .gnt_o(gnt_o), .gnt_s(gnt_s),
        .ocupado(ocupado), .timeout_s(timeout_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later; exclusivity is checked every step.
    task automatic step();
        @(posedge clk);
        #1;
        check("exclusive", {31'b0, gnt_o & gnt_s}, 32'd0);
    endtask

    task automatic grants(input string tag, input logic eo, input logic es);
        check({tag, ".gnt_o"}, {31'b0, gnt_o}, {31'b0, eo});
        check({tag, ".gnt_s"}, {31'b0, gnt_s}, {31'b0, es});
        check({tag, ".ocupado"}, {31'b0, ocupado}, {31'b0, eo | es});
    endtask

    task automatic st(input string tag, input estado_arb_t e);
        check({tag, ".estado"}, 32'(dut.estado_q), 32'(e));
    endtask

    initial begin
        rst = 1'b1; req_o = 1'b0; req_s = 1'b0; atividade_s = 1'b0;
        step(); step();
        grants("reset", 1'b0, 1'b0);
        st("reset", LIVRE);
        check("reset.timeout_s", {31'b0, timeout_s}, 32'd0);

        // 1: operational grant and release with a two-cycle gap
        rst = 1'b0; req_o = 1'b1;
        step(); grants("t1.grant", 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(); grants("t1.hold", 1'b1, 1'b0);
        end
        req_o = 1'b0;
        step(); grants("t1.gap0", 1'b0, 1'b0); st("t1.gap0", TROCA);
        step(); grants("t1.gap1", 1'b0, 1'b0); st("t1.gap1", TROCA);
        step(); grants("t1.livre", 1'b0, 1'b0); st("t1.livre", LIVRE);

        // 2: simultaneous requests, setup wins
        req_o = 1'b1; req_s = 1'b1;
        step(); grants("t2.setup_wins", 1'b0, 1'b1);
        req_o = 1'b0; req_s = 1'b0;
        step(); st("t2.troca", TROCA);
        step(); step(); st("t2.livre", LIVRE);

        // 3: preemption of operational only after the minimum hold
        req_o = 1'b1;
        step(); grants("t3.grant", 1'b1, 1'b0);
        req_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); grants("t3.hold", 1'b1, 1'b0);
            check("t3.hold_cnt", 32'(dut.hold_cnt), 32'(i + 1));
        end
        step(); grants("t3.gap0", 1'b0, 1'b0); st("t3.gap0", TROCA);
        step(); grants("t3.gap1", 1'b0, 1'b0);
        step(); grants("t3.livre", 1'b0, 1'b0); st("t3.livre", LIVRE);
        step(); grants("t3.setup", 1'b0, 1'b1);

        // 4: setup inactivity timeout, lock and re-grant after release
        req_o = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(); grants("t4.setup", 1'b0, 1'b1);
            check("t4.no_to", {31'b0, timeout_s}, 32'd0);
        end
        step(); grants("t4.revoked", 1'b0, 1'b0);
        check("t4.to_pulse", {31'b0, timeout_s}, 32'd1);
        check("t4.lock_set", {31'b0, dut.lock_s_q}, 32'd1);
        step(); check("t4.to_off", {31'b0, timeout_s}, 32'd0);
        step(); st("t4.livre", LIVRE);
        step(); grants("t4.locked", 1'b0, 1'b0); st("t4.locked", LIVRE);
        step(); grants("t4.locked2", 1'b0, 1'b0);
        req_s = 1'b0;
        step(); check("t4.lock_clr", {31'b0, dut.lock_s_q}, 32'd0);
        req_s = 1'b1;
        step(); grants("t4.regrant", 1'b0, 1'b1);

        // 5: periodic activity keeps setup alive despite req_o
        req_o = 1'b1;
        for (int i = 0; i < 40; i++) begin
            atividade_s = ((i % 5) == 4);
            step(); grants("t5.setup", 1'b0, 1'b1);
            check("t5.no_to", {31'b0, timeout_s}, 32'd0);
        end
        atividade_s = 1'b0;
        step(); step(); step();
        check("t5.idle_cnt", 32'(dut.idle_cnt), 32'd3);

        // 6: synchronous reset mid-setup drops the grant with no gap
        rst = 1'b1;
        step();
        grants("t6.rst", 1'b0, 1'b0);
        st("t6.rst", LIVRE);
        check("t6.lock", {31'b0, dut.lock_s_q}, 32'd0);
        check("t6.idle", 32'(dut.idle_cnt), 32'd0);
        check("t6.hold", 32'(dut.hold_cnt), 32'd0);
        check("t6.gap", 32'(dut.gap_cnt), 32'd0);
        check("t6.to", {31'b0, timeout_s}, 32'd0);
        rst = 1'b0; req_s = 1'b0;
        step(); grants("t6.after", 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
